traffic_light_monitor: RTL

Passive checker on the consuming side of the traffic-light lamp interface. Samples `red`/`yellow`/`green` every clock and tracks the current phase. Enforces the one-hot pattern, the RED→GREEN→YELLOW→RED order, and per-phase dwell limits. Reports a sticky fault with a code, a fault counter and a completed-cycle counter to the bench or system supervisor.

---
 rtl/traffic_light_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for a red/yellow/green lamp interface: tracks the current phase,
// enforces one-hot lamps, R->G->Y->R order and per-phase dwell limits.
module traffic_light_monitor #(
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 16,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             fault_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [7:0]       err_count,
  output logic [7:0]       cycles_done
);

  typedef enum logic [1:0] {SYNC = 2'd0, RED = 2'd1, GREEN = 2'd2, YELLOW = 2'd3} phase_t;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_ONEHOT = 3'd1;
  localparam logic [2:0] C_ORDER = 3'd2;
  localparam logic [2:0] C_SHORT = 3'd3;
  localparam logic [2:0] C_LONG  = 3'd4;

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [7:0]       err_q, err_d;
  logic [7:0]       cyc_q, cyc_d;
  logic             partial_q, partial_d;
  logic             long_q, long_d;
  // Set while disabled so the first enabled sample re-enters SYNC.
  logic             resync_q, resync_d;

  logic [2:0]       pat;
  logic             one_hot;
  phase_t           pat_ph, succ;
  logic [CNT_W-1:0] cur_min, cur_max;
  logic [2:0]       code_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      dwell_q   <= '0;
      fault_q   <= 1'b0;
      code_q    <= C_NONE;
      err_q     <= 8'd0;
      cyc_q     <= 8'd0;
      partial_q <= 1'b1;
      long_q    <= 1'b0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      partial_q <= partial_d;
      long_q    <= long_d;
      resync_q  <= resync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    fault_d   = fault_q;
    code_d    = code_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    partial_d = partial_q;
    long_d    = long_q;
    resync_d  = resync_q;
    code_now  = C_NONE;

    pat     = {red, yellow, green};
    one_hot = 1'b1;
    case (pat)
      3'b100:  pat_ph = RED;
      3'b010:  pat_ph = YELLOW;
      3'b001:  pat_ph = GREEN;
      default: begin pat_ph = SYNC; one_hot = 1'b0; end
    endcase

    case (state_q)
      RED:     begin succ = GREEN;  cur_min = CNT_W'(RED_MIN);    cur_max = CNT_W'(RED_MAX);    end
      GREEN:   begin succ = YELLOW; cur_min = CNT_W'(GREEN_MIN);  cur_max = CNT_W'(GREEN_MAX);  end
      YELLOW:  begin succ = RED;    cur_min = CNT_W'(YELLOW_MIN); cur_max = CNT_W'(YELLOW_MAX); end
      default: begin succ = SYNC;   cur_min = '0;                 cur_max = '0;                 end
    endcase

    if (!enable) begin
      resync_d = 1'b1;
    end else begin
      if (resync_q) begin
        state_d   = SYNC;
        dwell_d   = '0;
        partial_d = 1'b1;
        long_d    = 1'b0;
        resync_d  = 1'b0;
      end else if (state_q == SYNC) begin
        if (one_hot) begin
          state_d   = pat_ph;
          dwell_d   = CNT_W'(1);
          partial_d = 1'b1;
          long_d    = 1'b0;
        end
      end else if (!one_hot) begin
        code_now  = C_ONEHOT;
        state_d   = SYNC;
        dwell_d   = '0;
        partial_d = 1'b1;
        long_d    = 1'b0;
      end else if (pat_ph == state_q) begin
        if (dwell_q != '1) dwell_d = dwell_q + CNT_W'(1);
        if (dwell_q == cur_max && !long_q) begin
          code_now = C_LONG;
          long_d   = 1'b1;
        end
      end else if (pat_ph == succ) begin
        // A phase entered mid-way (partial) has an unknown true length, so skip the short check.
        if (!partial_q && dwell_q < cur_min) code_now = C_SHORT;
        state_d   = pat_ph;
        dwell_d   = CNT_W'(1);
        partial_d = 1'b0;
        long_d    = 1'b0;
        if (state_q == YELLOW) cyc_d = cyc_q + 8'd1;
      end else begin
        code_now  = C_ORDER;
        state_d   = pat_ph;
        dwell_d   = CNT_W'(1);
        partial_d = 1'b1;
        long_d    = 1'b0;
      end

      if (fault_clr) begin
        fault_d = 1'b0;
        code_d  = C_NONE;
      end
      if (code_now != C_NONE) begin
        fault_d = 1'b1;
        if (!fault_q || fault_clr) code_d = code_now;
        if (err_q != 8'hff) err_d = err_q + 8'd1;
      end
    end
  end

  assign phase       = state_q;
  assign dwell       = dwell_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign err_count   = err_q;
  assign cycles_done = cyc_q;

endmodule
